capture_sequencer: RTL
======================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the step limit and post-trigger counter.
REQ-002 SHALL have parameter PRE_W, default 16, width of the pre-trigger length and counter.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_arm  input  1  start-capture pulse.
REQ-006 SHALL have port i_abort  input  1  cancel capture.
REQ-007 SHALL have port i_sample_tick  input  1  one-cycle sample strobe.
REQ-008 SHALL have port i_trigger  input  1  trigger match; qualified by i_sample_tick.
REQ-009 SHALL have port do_step_limit  input  1  enables post-trigger step limit.
REQ-010 SHALL have port step_limit  input  CNT_W  post-trigger sample count.
REQ-011 SHALL have port pretrig_len  input  PRE_W  minimum pre-trigger samples.
REQ-012 SHALL have port o_run  output  1  capture active.
REQ-013 SHALL have port o_step  output  1  one-cycle store-sample pulse.
REQ-014 SHALL have port o_triggered  output  1  trigger accepted.
REQ-015 SHALL have port o_done  output  1  capture complete, level.
REQ-016 SHALL have port o_state  output  3  current state encoding.
REQ-017 SHALL have port o_post_cnt  output  CNT_W  post-trigger samples taken.

Function
REQ-018 SHALL implement states IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4; o_state SHALL equal the registered state.
REQ-019 SHALL latch do_step_limit, step_limit, pretrig_len on the accepted i_arm cycle; later changes SHALL not affect the capture in progress.
REQ-020 SHALL accept i_arm only in IDLE or DONE; arm in any other state SHALL be ignored.
REQ-021 On accepted arm: next state PRE if pretrig_len>0, else WAIT_TRIG; pre and post counters SHALL clear; o_done and o_triggered SHALL clear.
REQ-022 o_run SHALL be 1 exactly in PRE, WAIT_TRIG, POST.
REQ-023 In PRE, WAIT_TRIG, POST, each i_sample_tick SHALL produce o_step=1 on the following cycle (latency 1); no o_step in other states.
REQ-024 PRE: i_trigger SHALL be ignored; pre counter increments per tick; on the tick that brings count to pretrig_len, next state WAIT_TRIG.
REQ-025 WAIT_TRIG: i_trigger & i_sample_tick in the same cycle SHALL move to POST and set o_triggered; that sample counts as post sample 1.
REQ-026 POST: o_post_cnt increments per tick (the triggering tick included), wrapping modulo 2^CNT_W.
REQ-027 POST with latched do_step_limit=1: the tick making o_post_cnt equal the latched step_limit SHALL move to DONE; step_limit=0 SHALL behave as 1.
REQ-028 POST with latched do_step_limit=0: SHALL remain in POST until i_abort.
REQ-029 DONE: o_done=1, o_run=0, o_post_cnt held; exit only by accepted arm or i_abort.
REQ-030 i_abort SHALL, in any state, force IDLE next cycle and suppress o_step for a tick in the same cycle; abort SHALL take priority over arm and trigger.
REQ-031 The o_step pulse for the final tick SHALL still be issued, one cycle after the tick, in DONE.

Reset
REQ-032 On i_rst_n=0, immediately: state IDLE, o_run=0, o_step=0, o_triggered=0, o_done=0, o_post_cnt=0, latched configuration 0.
REQ-033 Reset mid-capture SHALL discard the capture; no o_step SHALL follow release.

Structure
REQ-034 State encodings SHALL reside in shared package la_pkg as localparams.
REQ-035 Pre/post counters SHALL reside in one sub-module capture_counter (load-clear, enable, compare-equal), instantiated twice.

Verification
REQ-036 pretrig_len=3, step_limit=5, limit on, trigger at tick 6 -> 10 o_step pulses, o_done after tick 10, o_post_cnt=5.
REQ-037 Trigger asserted at ticks 1-3 with pretrig_len=3 -> ignored; trigger at tick 4 accepted, o_triggered=1.
REQ-038 do_step_limit=0, 100 post ticks, then abort -> o_state stays 3, o_post_cnt=100, IDLE next cycle, o_done=0.
REQ-039 step_limit=0, pretrig_len=0, trigger on first tick -> exactly 1 o_step, DONE.
REQ-040 Abort and tick in the same cycle in POST -> no o_step; arm during WAIT_TRIG ignored.
REQ-041 i_rst_n low during POST with step_limit=8 after 4 ticks -> all outputs 0 immediately; re-arm restarts count from 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: sequencer state
// encodings and the state enum built from them.
package la_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRE       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST      = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_PRE       = ST_PRE,
    S_WAIT_TRIG = ST_WAIT_TRIG,
    S_POST      = ST_POST,
    S_DONE      = ST_DONE
  } state_e;

endpackage

// File: rtl/capture_counter.sv
// Sample counter with synchronous clear, count enable and a look-ahead
// compare that flags the enabled increment which lands on i_cmp.
module capture_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_cmp,
  output logic [W-1:0] o_count,
  output logic         o_hit_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] count_inc_c;

  always_comb begin
    count_inc_c = W'(count_q + W'(1));
    count_d     = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = count_inc_c;
    end
    o_hit_c = i_en && (count_inc_c == i_cmp);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms, collects a minimum pre-trigger window, waits for a
// qualified trigger, then issues store strobes until the post limit or abort.
module capture_sequencer
  import la_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_arm,
  input  logic             i_abort,
  input  logic             i_sample_tick,
  input  logic             i_trigger,
  input  logic             do_step_limit,
  input  logic [CNT_W-1:0] step_limit,
  input  logic [PRE_W-1:0] pretrig_len,
  output logic             o_run,
  output logic             o_step,
  output logic             o_triggered,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_post_cnt
);

  state_e             state_q, state_d;
  logic               run_q, run_d;
  logic               step_q, step_d;
  logic               trig_q, trig_d;
  logic               done_q, done_d;
  logic               lim_en_q, lim_en_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [PRE_W-1:0]   pre_len_q, pre_len_d;

  logic               cnt_clr_c;
  logic               active_c;
  logic               tick_ok_c;
  logic               pre_en_c;
  logic               post_en_c;
  logic               pre_hit_c;
  logic               post_hit_c;
  logic [CNT_W-1:0]   lim_eff_c;
  logic [PRE_W-1:0]   pre_cnt_unused;
  logic [CNT_W-1:0]   post_cnt;

  // A latched limit of zero is treated as a limit of one.
  always_comb begin
    lim_eff_c = (lim_q == '0) ? CNT_W'(1) : lim_q;
    active_c  = state_q inside {S_PRE, S_WAIT_TRIG, S_POST};
    tick_ok_c = i_sample_tick && !i_abort;
    pre_en_c  = tick_ok_c && (state_q == S_PRE);
    post_en_c = tick_ok_c && ((state_q == S_POST) ||
                              ((state_q == S_WAIT_TRIG) && i_trigger));
  end

  capture_counter #(.W(PRE_W)) u_pre_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr_c),
    .i_en    (pre_en_c),
    .i_cmp   (pre_len_q),
    .o_count (pre_cnt_unused),
    .o_hit_c (pre_hit_c)
  );

  capture_counter #(.W(CNT_W)) u_post_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr_c),
    .i_en    (post_en_c),
    .i_cmp   (lim_eff_c),
    .o_count (post_cnt),
    .o_hit_c (post_hit_c)
  );

  // Next-state and registered-output decode; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    trig_d    = trig_q;
    lim_en_d  = lim_en_q;
    lim_d     = lim_q;
    pre_len_d = pre_len_q;
    cnt_clr_c = 1'b0;
    step_d    = tick_ok_c && active_c;

    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            lim_en_d  = do_step_limit;
            lim_d     = step_limit;
            pre_len_d = pretrig_len;
            cnt_clr_c = 1'b1;
            trig_d    = 1'b0;
            state_d   = (pretrig_len != '0) ? S_PRE : S_WAIT_TRIG;
          end
        end
        S_PRE: begin
          if (pre_hit_c) begin
            state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (post_en_c) begin
            trig_d  = 1'b1;
            state_d = (lim_en_q && post_hit_c) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (lim_en_q && post_hit_c) begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    run_d  = state_d inside {S_PRE, S_WAIT_TRIG, S_POST};
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      lim_en_q  <= 1'b0;
      lim_q     <= '0;
      pre_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      step_q    <= step_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      lim_en_q  <= lim_en_d;
      lim_q     <= lim_d;
      pre_len_q <= pre_len_d;
    end
  end

  assign o_run       = run_q;
  assign o_step      = step_q;
  assign o_triggered = trig_q;
  assign o_done      = done_q;
  assign o_state     = state_q;
  assign o_post_cnt  = post_cnt;

endmodule
